// File: rtl/bsg_cgol_ctrl.sv
// bsg_cgol_ctrl
//   Sequencing controller for a Game of Life cell array. It accepts an initial
//   board plus a generation count on a valid/ready handshake. It loads the
//   board into every cell with a one-cycle update strobe, then raises the
//   array-wide step enable for the requested number of generations. The final
//   board, read back from the cells, is offered on a valid/yumi handshake.
//
// Ports
//   clk_i         clock
//   reset_n_i     asynchronous active-low reset
//   data_i        initial board, bit r*board_width_p+c is cell (r,c), 1 = alive
//   frames_i      generations to simulate; values above max_game_length_p are clamped
//   v_i / ready_o input handshake
//   en_o          step enable to every cell
//   update_o      load strobe to every cell
//   update_val_o  per-cell load value, bit i to cell i
//   board_i       collected cell outputs
//   data_o        final board, valid while v_o=1
//   v_o / yumi_i  output handshake
module bsg_cgol_ctrl #(
    parameter int board_width_p     = 8,
    parameter int max_game_length_p = 1024
) (
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic [board_width_p*board_width_p-1:0]       data_i,
    input  logic [$clog2(max_game_length_p+1)-1:0]       frames_i,
    input  logic                                         v_i,
    output logic                                         ready_o,
    output logic                                         en_o,
    output logic                                         update_o,
    output logic [board_width_p*board_width_p-1:0]       update_val_o,
    input  logic [board_width_p*board_width_p-1:0]       board_i,
    output logic [board_width_p*board_width_p-1:0]       data_o,
    output logic                                         v_o,
    input  logic                                         yumi_i
);

    localparam int CW  = $clog2(max_game_length_p + 1);
    localparam int BW2 = board_width_p * board_width_p;
    localparam logic [CW-1:0] MAX_FRAMES = CW'(max_game_length_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [BW2-1:0]   update_val_q;
    logic             ready_q;
    logic             en_q;
    logic             update_q;
    logic             v_q;
    logic [CW-1:0]    frames_clamped;

    // Clamping at load time means the down-counter can never wrap.
    assign frames_clamped = (frames_i > MAX_FRAMES) ? MAX_FRAMES : frames_i;

    // Each output flag is registered alongside the state it belongs to, so it
    // is set on the edge that enters that state.
    // NOTE: all state here uses non-blocking assignments; every register,
    // including the output flags, is cleared by the asynchronous reset so en_o,
    // update_o and v_o drop the moment reset_n_i falls. ready_q also resets to
    // 0, which keeps ready_o low during reset and raises it on the first edge
    // after release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            update_val_q <= '0;
            ready_q      <= 1'b0;
            en_q         <= 1'b0;
            update_q     <= 1'b0;
            v_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_i && ready_q) begin
                        update_val_q <= data_i;
                        cnt_q        <= frames_clamped;
                        ready_q      <= 1'b0;
                        update_q     <= 1'b1;
                        state_q      <= LOAD;
                    end else begin
                        ready_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    update_q <= 1'b0;
                    if (cnt_q == '0) begin
                        v_q     <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        en_q    <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    // The cycle seen with cnt_q==1 is the last enabled cycle.
                    if (cnt_q == CW'(1)) begin
                        en_q    <= 1'b0;
                        v_q     <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        v_q     <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign en_o         = en_q;
    assign update_o     = update_q;
    assign v_o          = v_q;
    assign update_val_o = update_val_q;
    // The cells hold their state while en_o and update_o are low, so the board
    // can be passed straight through.
    assign data_o       = board_i;

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
module tb_bsg_cgol_ctrl;

    localparam int W   = 8;
    localparam int MAX = 1024;
    localparam int FW  = $clog2(MAX + 1);
    localparam int BW2 = W * W;

    localparam logic [BW2-1:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [BW2-1:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [BW2-1:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [BW2-1:0] MIXED   = 64'hA5A5_5A5A_0F0F_F0F0;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [BW2-1:0] data_i = '0;
    logic [FW-1:0]  frames_i = '0;
    logic           v_i = 1'b0;
    logic           ready_o;
    logic           en_o;
    logic           update_o;
    logic [BW2-1:0] update_val_o;
    logic [BW2-1:0] board_i;
    logic [BW2-1:0] data_o;
    logic           v_o;
    logic           yumi_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bsg_cgol_ctrl #(
        .board_width_p    (W),
        .max_game_length_p(MAX)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .data_i      (data_i),
        .frames_i    (frames_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .en_o        (en_o),
        .update_o    (update_o),
        .update_val_o(update_val_o),
        .board_i     (board_i),
        .data_o      (data_o),
        .v_o         (v_o),
        .yumi_i      (yumi_i)
    );

    // Behavioural cell array: fixed dead border, standard B3/S23 rule.
    function automatic logic [BW2-1:0] life(input logic [BW2-1:0] b);
        logic [BW2-1:0] nb;
        nb = '0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < W
                            && c + dc >= 0 && c + dc < W && b[(r + dr) * W + c + dc])
                            n++;
                    end
                end
                nb[r * W + c] = b[r * W + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nb;
    endfunction

    logic [BW2-1:0] cells = '0;
    always @(posedge clk) begin
        if (update_o)  cells <= update_val_o;
        else if (en_o) cells <= life(cells);
    end
    assign board_i = cells;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full game: accept, count strobes and latency, optional backpressure, yumi.
    task automatic run_game(input string name, input logic [FW-1:0] f, input logic [BW2-1:0] d,
                            input logic [BW2-1:0] exp_board, input int exp_en, input int hold);
        int n, en_cnt, upd_cnt, both, wait_n;
        bit hold_bad;
        en_cnt = 0; upd_cnt = 0; both = 0; wait_n = 0; hold_bad = 0;
        @(negedge clk);
        data_i = d; frames_i = f; v_i = 1'b1;
        while (!ready_o && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check({name, " ready"}, 64'(ready_o), 64'd1);
        @(negedge clk);
        v_i = 1'b0; data_i = ~d; frames_i = '0;
        n = 0;
        while (!v_o && n < exp_en + 20) begin
            if (en_o) en_cnt++;
            if (update_o) upd_cnt++;
            if (en_o && update_o) both++;
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(exp_en + 1));
        check({name, " en_cycles"}, 64'(en_cnt), 64'(exp_en));
        check({name, " update_cycles"}, 64'(upd_cnt), 64'd1);
        check({name, " en_and_update"}, 64'(both), 64'd0);
        check({name, " data_o"}, data_o, exp_board);
        check({name, " update_val"}, update_val_o, d);
        check({name, " ready_in_done"}, 64'(ready_o), 64'd0);
        if (hold > 0) begin
            v_i = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!v_o || data_o !== exp_board || en_o || update_o || ready_o) hold_bad = 1'b1;
            end
            v_i = 1'b0;
            check({name, " backpressure_hold"}, 64'(hold_bad), 64'd0);
            check({name, " update_val_held"}, update_val_o, d);
        end
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i = 1'b0;
        check({name, " ready_after_yumi"}, 64'(ready_o), 64'd1);
        check({name, " v_after_yumi"}, 64'(v_o), 64'd0);
    endtask

    typedef struct {
        string          name;
        logic [FW-1:0]  frames;
        logic [BW2-1:0] data;
        logic [BW2-1:0] exp_board;
        int             exp_en;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt, n, na, nv;
        int acc_t[2];
        int vo_t[2];
        bit bad;

        vecs[0] = '{"blinker_f1", FW'(1),    BLINK_H, BLINK_V, 1};
        vecs[1] = '{"zero_gen",   FW'(0),    MIXED,   MIXED,   0};
        vecs[2] = '{"blinker_f4", FW'(4),    BLINK_H, BLINK_H, 4};
        vecs[3] = '{"block_f3",   FW'(3),    BLOCK,   BLOCK,   3};
        vecs[4] = '{"at_max",     FW'(1024), BLINK_H, BLINK_H, 1024};
        vecs[5] = '{"clamp",      FW'(2047), BLINK_H, BLINK_H, 1024};

        // Reset state while reset is held.
        #12;
        check("rst ready", 64'(ready_o), 64'd0);
        check("rst v", 64'(v_o), 64'd0);
        check("rst en", 64'(en_o), 64'd0);
        check("rst update", 64'(update_o), 64'd0);
        check("rst update_val", update_val_o, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst ready", 64'(ready_o), 64'd1);

        // yumi while v_o=0 is ignored.
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i = 1'b0;
        check("stray_yumi v", 64'(v_o), 64'd0);
        check("stray_yumi ready", 64'(ready_o), 64'd1);

        foreach (vecs[i])
            run_game(vecs[i].name, vecs[i].frames, vecs[i].data, vecs[i].exp_board, vecs[i].exp_en, 0);

        // Backpressure for 10 cycles in DONE, with v_i asserted and ignored.
        run_game("backpressure", FW'(1), BLINK_H, BLINK_V, 1, 10);

        // Reset mid-BUSY at generation 37 of 100.
        @(negedge clk);
        data_i = BLINK_H; frames_i = FW'(100); v_i = 1'b1;
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        v_i = 1'b0;
        en_cnt = 0; n = 0;
        while (en_cnt < 37 && n < 200) begin
            @(negedge clk);
            n++;
            if (en_o) en_cnt++;
        end
        check("midbusy en_before", 64'(en_o), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("midbusy en_async", 64'(en_o), 64'd0);
        check("midbusy update_async", 64'(update_o), 64'd0);
        check("midbusy v_async", 64'(v_o), 64'd0);
        check("midbusy ready_in_rst", 64'(ready_o), 64'd0);
        check("midbusy update_val_rst", update_val_o, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midbusy ready_after", 64'(ready_o), 64'd1);
        check("midbusy v_after", 64'(v_o), 64'd0);
        check("midbusy update_val_after", update_val_o, 64'd0);
        run_game("after_reset", FW'(1), BLINK_H, BLINK_V, 1, 0);

        // Back-to-back: v_i held, yumi_i tied high, F=1 -> 4 cycles per game.
        @(negedge clk);
        data_i = BLINK_H; frames_i = FW'(1); v_i = 1'b1; yumi_i = 1'b1;
        na = 0; nv = 0; bad = 0;
        acc_t = '{0, 0}; vo_t = '{0, 0};
        for (int i = 0; i < 40 && nv < 2; i++) begin
            if (ready_o && v_i && na < 2) begin
                acc_t[na] = i;
                na++;
            end
            if (v_o) begin
                if (data_o !== BLINK_V) bad = 1'b1;
                vo_t[nv] = i;
                nv++;
                if (nv == 2) v_i = 1'b0;
            end
            @(negedge clk);
        end
        yumi_i = 1'b0;
        check("b2b accepts", 64'(na), 64'd2);
        check("b2b results", 64'(nv), 64'd2);
        check("b2b period", 64'(acc_t[1] - acc_t[0]), 64'd4);
        check("b2b latency0", 64'(vo_t[0] - acc_t[0]), 64'd3);
        check("b2b latency1", 64'(vo_t[1] - acc_t[1]), 64'd3);
        check("b2b data", 64'(bad), 64'd0);
        @(negedge clk);
        check("b2b idle ready", 64'(ready_o), 64'd1);
        check("b2b idle v", 64'(v_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
